// File: rtl/data_mem_stage.sv
// Memory stage: byte/halfword/word loads and stores into a local word RAM,
// with a single registered write-back stage and fault flagging.
module data_mem_stage #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  output logic        out_valid,
  output logic [31:0] wb_data,
  output logic        was_load,
  output logic        mem_fault
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem [DEPTH];

  logic [29:0] word_idx;
  logic [1:0]  offset;
  logic [AW-1:0] ram_idx;
  logic        is_mem;
  logic        legal_f3;
  logic        misaligned;
  logic        in_range;
  logic        fault;
  logic        do_write;
  logic [3:0]  byte_en;
  logic [31:0] write_lanes;
  logic [31:0] rd_word;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] next_wb;

  assign word_idx = alu_result[31:2];
  assign offset   = alu_result[1:0];
  assign ram_idx  = word_idx[AW-1:0];
  assign is_mem   = mem_read | mem_write;
  assign in_range = (word_idx < 30'(DEPTH));

  always_comb begin
    legal_f3   = 1'b0;
    misaligned = 1'b0;
    if (mem_write) begin
      legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      legal_f3 = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
    end
    if (funct3[1:0] == 2'b01) misaligned = offset[0];
    if (funct3[1:0] == 2'b10) misaligned = (offset != 2'b00);
  end

  assign fault    = in_valid & is_mem &
                    ((mem_read & mem_write) | ~legal_f3 | misaligned | ~in_range);
  assign do_write = in_valid & mem_write & ~fault;

  // Stores replicate the source so every lane sees its byte; enables pick lanes.
  always_comb begin
    byte_en     = 4'b0000;
    write_lanes = write_data;
    case (funct3[1:0])
      2'b00: begin
        byte_en     = 4'b0001 << offset;
        write_lanes = {4{write_data[7:0]}};
      end
      2'b01: begin
        byte_en     = 4'b0011 << offset;
        write_lanes = {2{write_data[15:0]}};
      end
      default: begin
        byte_en     = 4'b1111;
        write_lanes = write_data;
      end
    endcase
  end

  assign rd_word = mem[ram_idx];
  assign shifted = rd_word >> {offset, 3'b000};

  always_comb begin
    case (funct3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'b0, shifted[7:0]};
      3'b101:  load_val = {16'b0, shifted[15:0]};
      default: load_val = 32'b0;
    endcase
  end

  always_comb begin
    next_wb = 32'b0;
    if (in_valid) begin
      if (mem_read) next_wb = fault ? 32'b0 : load_val;
      else          next_wb = alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      wb_data   <= 32'b0;
      was_load  <= 1'b0;
      mem_fault <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'b0;
    end else begin
      out_valid <= in_valid;
      wb_data   <= next_wb;
      was_load  <= in_valid & mem_read;
      mem_fault <= fault;
      if (do_write) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en[b]) mem[ram_idx][8*b +: 8] <= write_lanes[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed, table-driven bench for data_mem_stage (DEPTH = 64) with
// hand-written sequences for reset behaviour.
module tb_data_mem_stage;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic        out_valid;
  logic [31:0] wb_data;
  logic        was_load;
  logic        mem_fault;

  int checks;
  int failures;

  typedef struct {
    string       name;
    logic        valid;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_valid;
    logic [31:0] exp_wb;
    logic        chk_wb;
    logic        exp_fault;
    logic        exp_load;
  } vec_t;

  vec_t vecs[$];

  data_mem_stage #(.DEPTH(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .alu_result (alu_result),
    .write_data (write_data),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .out_valid  (out_valid),
    .wb_data    (wb_data),
    .was_load   (was_load),
    .mem_fault  (mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string n, input logic v, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                              input logic ev, input logic [31:0] ewb, input logic cw,
                              input logic ef, input logic el);
    vec_t r;
    r.name = n; r.valid = v; r.rd = rd; r.wr = wr; r.f3 = f3; r.addr = a; r.wdata = wd;
    r.exp_valid = ev; r.exp_wb = ewb; r.chk_wb = cw; r.exp_fault = ef; r.exp_load = el;
    return r;
  endfunction

  // Drives one instruction, clocks it in and leaves time just past the edge.
  task automatic apply_stimulus(input logic v, input logic rd, input logic wr,
                                input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd);
    in_valid   = v;
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    alu_result = a;
    write_data = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs.push_back(mk("lw_0_after_reset", 1,1,0,F_W, 32'h00, 32'h0,        1, 32'h00000000, 1, 0, 1));
    vecs.push_back(mk("sw_10",            1,0,1,F_W, 32'h10, 32'h800000F1, 1, 32'h00000010, 1, 0, 0));
    vecs.push_back(mk("lw_10",            1,1,0,F_W, 32'h10, 32'h0,        1, 32'h800000F1, 1, 0, 1));
    vecs.push_back(mk("lh_12",            1,1,0,F_H, 32'h12, 32'h0,        1, 32'hFFFF8000, 1, 0, 1));
    vecs.push_back(mk("lhu_12",           1,1,0,F_HU,32'h12, 32'h0,        1, 32'h00008000, 1, 0, 1));
    vecs.push_back(mk("lb_10",            1,1,0,F_B, 32'h10, 32'h0,        1, 32'hFFFFFFF1, 1, 0, 1));
    vecs.push_back(mk("lbu_10",           1,1,0,F_BU,32'h10, 32'h0,        1, 32'h000000F1, 1, 0, 1));
    vecs.push_back(mk("sw_20",            1,0,1,F_W, 32'h20, 32'h11223344, 1, 32'h00000020, 1, 0, 0));
    vecs.push_back(mk("sb_21",            1,0,1,F_B, 32'h21, 32'h123456AB, 1, 32'h00000021, 1, 0, 0));
    vecs.push_back(mk("lw_20_after_sb",   1,1,0,F_W, 32'h20, 32'h0,        1, 32'h1122AB44, 1, 0, 1));
    vecs.push_back(mk("sh_22",            1,0,1,F_H, 32'h22, 32'hCAFEBEEF, 1, 32'h00000022, 1, 0, 0));
    vecs.push_back(mk("lw_20_after_sh",   1,1,0,F_W, 32'h20, 32'h0,        1, 32'hBEEFAB44, 1, 0, 1));
    vecs.push_back(mk("sw_04",            1,0,1,F_W, 32'h04, 32'h01020304, 1, 32'h00000004, 1, 0, 0));
    vecs.push_back(mk("sw_06_misaligned", 1,0,1,F_W, 32'h06, 32'hFFFFFFFF, 1, 32'h00000006, 1, 1, 0));
    vecs.push_back(mk("lw_04_unchanged",  1,1,0,F_W, 32'h04, 32'h0,        1, 32'h01020304, 1, 0, 1));
    vecs.push_back(mk("lh_03_misaligned", 1,1,0,F_H, 32'h03, 32'h0,        1, 32'h00000000, 1, 1, 1));
    vecs.push_back(mk("lw_02_misaligned", 1,1,0,F_W, 32'h02, 32'h0,        1, 32'h00000000, 1, 1, 1));
    vecs.push_back(mk("rd_and_wr",        1,1,1,F_W, 32'h04, 32'hDEADDEAD, 1, 32'h00000000, 0, 1, 1));
    vecs.push_back(mk("lw_04_after_rdwr", 1,1,0,F_W, 32'h04, 32'h0,        1, 32'h01020304, 1, 0, 1));
    vecs.push_back(mk("sw_fc_last",       1,0,1,F_W, 32'hFC, 32'h5A5A5A5A, 1, 32'h000000FC, 1, 0, 0));
    vecs.push_back(mk("lw_fc_last",       1,1,0,F_W, 32'hFC, 32'h0,        1, 32'h5A5A5A5A, 1, 0, 1));
    vecs.push_back(mk("lw_100_range",     1,1,0,F_W, 32'h100,32'h0,        1, 32'h00000000, 1, 1, 1));
    vecs.push_back(mk("sw_100_range",     1,0,1,F_W, 32'h100,32'h77777777, 1, 32'h00000100, 1, 1, 0));
    vecs.push_back(mk("lw_0_no_wrap",     1,1,0,F_W, 32'h00, 32'h0,        1, 32'h00000000, 1, 0, 1));
    vecs.push_back(mk("load_f3_011",      1,1,0,3'b011,32'h00,32'h0,       1, 32'h00000000, 1, 1, 1));
    vecs.push_back(mk("store_f3_100",     1,0,1,3'b100,32'h08,32'h000000FF,1, 32'h00000008, 1, 1, 0));
    vecs.push_back(mk("lw_08_unchanged",  1,1,0,F_W, 32'h08, 32'h0,        1, 32'h00000000, 1, 0, 1));
    vecs.push_back(mk("pass_through",     1,0,0,3'b111,32'hDEADBEEF,32'h0, 1, 32'hDEADBEEF, 1, 0, 0));
    vecs.push_back(mk("idle_store",       0,0,1,F_W, 32'h10, 32'h99999999, 0, 32'h00000000, 1, 0, 0));
    vecs.push_back(mk("lw_10_after_idle", 1,1,0,F_W, 32'h10, 32'h0,        1, 32'h800000F1, 1, 0, 1));

    rst_n = 1'b0;
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; alu_result = 32'h0; write_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset/out_valid", {31'b0, out_valid}, 32'd0);
    check_output("reset/wb_data",   wb_data,             32'd0);
    check_output("reset/mem_fault", {31'b0, mem_fault}, 32'd0);
    check_output("reset/was_load",  {31'b0, was_load},  32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].valid, vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      check_output({vecs[i].name, "/out_valid"}, {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].chk_wb) check_output({vecs[i].name, "/wb_data"}, wb_data, vecs[i].exp_wb);
      check_output({vecs[i].name, "/mem_fault"}, {31'b0, mem_fault}, {31'b0, vecs[i].exp_fault});
      check_output({vecs[i].name, "/was_load"},  {31'b0, was_load},  {31'b0, vecs[i].exp_load});
    end

    // Reset mid-stream: the store at the reset edge is dropped and the RAM clears.
    apply_stimulus(1, 0, 1, F_W, 32'h00, 32'h12345678);
    check_output("mid_sw_0/out_valid", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    apply_stimulus(1, 0, 1, F_W, 32'h04, 32'hFFFFFFFF);
    check_output("mid_rst/out_valid", {31'b0, out_valid}, 32'd0);
    check_output("mid_rst/wb_data",   wb_data,             32'd0);
    check_output("mid_rst/mem_fault", {31'b0, mem_fault}, 32'd0);
    rst_n = 1'b1;
    apply_stimulus(1, 1, 0, F_W, 32'h00, 32'h0);
    check_output("post_rst_lw_0/out_valid", {31'b0, out_valid}, 32'd1);
    check_output("post_rst_lw_0/wb_data",   wb_data,             32'd0);
    apply_stimulus(1, 1, 0, F_W, 32'h04, 32'h0);
    check_output("post_rst_lw_4/wb_data",   wb_data,             32'd0);
    apply_stimulus(1, 1, 0, F_W, 32'h20, 32'h0);
    check_output("post_rst_lw_20/wb_data",  wb_data,             32'd0);

    // Back-to-back store then load of the same word sees the new data.
    apply_stimulus(1, 0, 1, F_W, 32'h30, 32'hA5A50F0F);
    apply_stimulus(1, 1, 0, F_BU, 32'h33, 32'h0);
    check_output("st_ld_b2b/wb_data", wb_data, 32'h000000A5);
    apply_stimulus(0, 0, 0, F_W, 32'h0, 32'h0);
    check_output("idle/out_valid", {31'b0, out_valid}, 32'd0);
    check_output("idle/wb_data",   wb_data,             32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
